// File: rtl/cfg_frame_loader.sv
// Byte-serial configuration loader: parses header/count/frames, verifies each frame's XOR checksum,
// then presents the frame on cfg_bits with one cycle of setup and hold around a one-hot wr_en pulse.
module cfg_frame_loader #(
  parameter int FRAME_W  = 18,
  parameter int N_BLOCKS = 4,
  parameter int WR_HOLD  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [FRAME_W-1:0]  cfg_bits,
  output logic [N_BLOCKS-1:0] wr_en,
  output logic                busy,
  output logic                done,
  output logic                err_chk,
  output logic                err_addr
);

  localparam int P   = (FRAME_W + 7) / 8;
  localparam int BCW = (P > 1) ? $clog2(P) : 1;
  localparam int HCW = (WR_HOLD > 1) ? $clog2(WR_HOLD) : 1;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_COUNT = 4'd1;
  localparam logic [3:0] S_ADDR  = 4'd2;
  localparam logic [3:0] S_DATA  = 4'd3;
  localparam logic [3:0] S_CHK   = 4'd4;
  localparam logic [3:0] S_SETUP = 4'd5;
  localparam logic [3:0] S_WRITE = 4'd6;
  localparam logic [3:0] S_HOLD  = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;

  logic [3:0]          state_reg, state_next;
  logic [7:0]          count_reg, addr_reg, chk_reg;
  logic [FRAME_W-1:0]  frame_reg, frame_next, cfg_bits_reg;
  logic [BCW-1:0]      byte_cnt_reg;
  logic [HCW-1:0]      hold_cnt_reg;
  logic [N_BLOCKS-1:0] wr_en_reg, addr_onehot;
  logic                err_chk_reg, err_addr_reg;
  logic                xfer, addr_ok, chk_ok, last_frame;

  assign in_ready   = !rst && (state_reg inside {S_IDLE, S_COUNT, S_ADDR, S_DATA, S_CHK});
  assign xfer       = in_valid && in_ready;
  assign addr_ok    = {1'b0, addr_reg} < 9'(N_BLOCKS);
  assign chk_ok     = (in_data == chk_reg);
  assign last_frame = (count_reg == 8'd1);

  assign busy     = (state_reg != S_IDLE) && (state_reg != S_DONE);
  assign done     = (state_reg == S_DONE);
  assign cfg_bits = cfg_bits_reg;
  assign wr_en    = wr_en_reg;
  assign err_chk  = err_chk_reg;
  assign err_addr = err_addr_reg;

  // Payload byte k lands in frame bits [8k+7:8k]; bits at or above FRAME_W are never stored.
  generate
    for (genvar gi = 0; gi < FRAME_W; gi++) begin : g_frame_bit
      assign frame_next[gi] = (byte_cnt_reg == BCW'(gi / 8)) ? in_data[gi % 8] : frame_reg[gi];
    end
    for (genvar gi = 0; gi < N_BLOCKS; gi++) begin : g_onehot
      assign addr_onehot[gi] = (addr_reg == 8'(gi));
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (xfer && in_data == 8'hA5) state_next = S_COUNT;
      S_COUNT: if (xfer) state_next = (in_data == 8'd0) ? S_DONE : S_ADDR;
      S_ADDR:  if (xfer) state_next = S_DATA;
      S_DATA:  if (xfer && byte_cnt_reg == BCW'(P - 1)) state_next = S_CHK;
      S_CHK: begin
        if (xfer) begin
          if (!chk_ok || !addr_ok) state_next = last_frame ? S_DONE : S_ADDR;
          else                     state_next = S_SETUP;
        end
      end
      S_SETUP: state_next = S_WRITE;
      S_WRITE: if (hold_cnt_reg == HCW'(WR_HOLD - 1)) state_next = S_HOLD;
      S_HOLD:  state_next = last_frame ? S_DONE : S_ADDR;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      count_reg    <= '0;
      addr_reg     <= '0;
      chk_reg      <= '0;
      frame_reg    <= '0;
      cfg_bits_reg <= '0;
      byte_cnt_reg <= '0;
      hold_cnt_reg <= '0;
      wr_en_reg    <= '0;
      err_chk_reg  <= 1'b0;
      err_addr_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      // Registered so the latch enables never see decode glitches.
      wr_en_reg <= (state_next == S_WRITE) ? addr_onehot : '0;
      case (state_reg)
        S_IDLE: begin
          if (xfer && in_data == 8'hA5) begin
            err_chk_reg  <= 1'b0;
            err_addr_reg <= 1'b0;
          end
        end
        S_COUNT: if (xfer) count_reg <= in_data;
        S_ADDR: begin
          if (xfer) begin
            addr_reg     <= in_data;
            chk_reg      <= in_data;
            frame_reg    <= '0;
            byte_cnt_reg <= '0;
          end
        end
        S_DATA: begin
          if (xfer) begin
            frame_reg    <= frame_next;
            chk_reg      <= chk_reg ^ in_data;
            byte_cnt_reg <= byte_cnt_reg + BCW'(1);
          end
        end
        S_CHK: begin
          if (xfer) begin
            if (!chk_ok) begin
              err_chk_reg <= 1'b1;
              count_reg   <= count_reg - 8'd1;
            end else if (!addr_ok) begin
              err_addr_reg <= 1'b1;
              count_reg    <= count_reg - 8'd1;
            end else begin
              cfg_bits_reg <= frame_reg;
            end
          end
        end
        S_SETUP: hold_cnt_reg <= '0;
        S_WRITE: hold_cnt_reg <= hold_cnt_reg + HCW'(1);
        S_HOLD:  count_reg <= count_reg - 8'd1;
        default: ;
      endcase
    end
  end

endmodule
